// File: rtl/alu_pkg.sv
// alu_pkg: opcodes and FSM state encoding shared by seq_alu and its mul/div datapath
package alu_pkg;
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_SLTU  = 4'b0100;
  localparam logic [3:0] ALU_XOR   = 4'b0101;
  localparam logic [3:0] ALU_SLT   = 4'b0110;
  localparam logic [3:0] ALU_SLL   = 4'b0111;
  localparam logic [3:0] ALU_SRL   = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1001;
  localparam logic [3:0] ALU_MUL   = 4'b1010;
  localparam logic [3:0] ALU_MULHU = 4'b1011;
  localparam logic [3:0] ALU_DIVU  = 4'b1100;
  localparam logic [3:0] ALU_REMU  = 4'b1101;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
endpackage

// File: rtl/seq_alu_muldiv.sv
// seq_alu_muldiv: iterative shift-add multiplier / restoring divider, one step per cycle
// Ports: i_load loads operands and counter=WIDTH; i_step advances one step (i_div picks divide);
// o_last flags the final step; o_lo_n/o_hi_n are the register values after the current step
// (mul: low/high product, div: quotient/remainder).
module seq_alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_last,
  output logic [WIDTH-1:0] o_lo_n,
  output logic [WIDTH-1:0] o_hi_n
);
  logic [WIDTH-1:0] r_lo, r_hi, r_b;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH:0]   w_sum, w_sh, w_diff;
  logic             w_ok;
  // mul: {hi,lo} holds {accumulator, multiplier}; div: {hi,lo} holds {remainder, dividend}
  assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_sh   = {r_hi, r_lo[WIDTH-1]};
  assign w_diff = w_sh - {1'b0, r_b};
  assign w_ok   = !w_diff[WIDTH];
  assign o_hi_n = i_div ? (w_ok ? w_diff[WIDTH-1:0] : w_sh[WIDTH-1:0]) : w_sum[WIDTH:1];
  assign o_lo_n = i_div ? {r_lo[WIDTH-2:0], w_ok} : {w_sum[0], r_lo[WIDTH-1:1]};
  assign o_last = r_cnt == CNT_W'(1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lo  <= '0;
      r_hi  <= '0;
      r_b   <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_lo  <= i_a;
      r_hi  <= '0;
      r_b   <= i_b;
      r_cnt <= CNT_W'(WIDTH);
    end else if (i_step) begin
      r_lo  <= o_lo_n;
      r_hi  <= o_hi_n;
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with single-cycle ops and iterative mul/div under a start/ready/done handshake
// Ports: start/alu_function/input_a/input_b captured while ready=1; done pulses one cycle with
// alu_output/zero valid; alu_output/zero hold until the next done.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_function,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] alu_output,
  output logic             zero
);
  localparam int SH_W = $clog2(WIDTH);
  state_t           r_state;
  logic             r_hi_sel;
  logic [WIDTH-1:0] w_res, w_lo_n, w_hi_n, w_md_res;
  logic [SH_W-1:0]  w_sh;
  logic             w_is_mul, w_is_div, w_div0, w_load, w_last;
  assign w_sh     = input_b[SH_W-1:0];
  assign w_is_mul = alu_function[3:1] == 3'b101;
  assign w_is_div = alu_function[3:1] == 3'b110;
  assign w_div0   = w_is_div && input_b == '0;
  assign w_load   = r_state == S_IDLE && start && (w_is_mul || (w_is_div && !w_div0));
  // odd opcodes of the mul/div group (mulhu, remu) take the high half
  assign w_md_res = r_hi_sel ? w_hi_n : w_lo_n;
  always_comb begin
    w_res = '0;
    case (alu_function)
      ALU_ADD:  w_res = input_a + input_b;
      ALU_SUB:  w_res = input_a - input_b;
      ALU_AND:  w_res = input_a & input_b;
      ALU_OR:   w_res = input_a | input_b;
      ALU_SLTU: w_res = {{(WIDTH-1){1'b0}}, input_a < input_b};
      ALU_XOR:  w_res = input_a ^ input_b;
      ALU_SLT:  w_res = {{(WIDTH-1){1'b0}}, $signed(input_a) < $signed(input_b)};
      ALU_SLL:  w_res = input_a << w_sh;
      ALU_SRL:  w_res = input_a >> w_sh;
      ALU_SRA:  w_res = $signed(input_a) >>> w_sh;
      ALU_DIVU: w_res = '1;
      ALU_REMU: w_res = input_a;
      default:  w_res = '0;
    endcase
  end
  seq_alu_muldiv #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_md (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_step (r_state == S_MUL || r_state == S_DIV),
    .i_div  (r_state == S_DIV),
    .i_a    (input_a),
    .i_b    (input_b),
    .o_last (w_last),
    .o_lo_n (w_lo_n),
    .o_hi_n (w_hi_n)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_hi_sel   <= 1'b0;
      ready      <= 1'b1;
      done       <= 1'b0;
      alu_output <= '0;
      zero       <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_hi_sel <= alu_function[0];
          ready    <= 1'b0;
          if (w_is_mul) r_state <= S_MUL;
          else if (w_is_div && !w_div0) r_state <= S_DIV;
          else begin
            r_state    <= S_DONE;
            done       <= 1'b1;
            alu_output <= w_res;
            zero       <= w_res == '0;
          end
        end
        S_MUL, S_DIV: if (w_last) begin
          r_state    <= S_DONE;
          done       <= 1'b1;
          alu_output <= w_md_res;
          zero       <= w_md_res == '0;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          done    <= 1'b0;
          ready   <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench for seq_alu at WIDTH=32 and WIDTH=8
module tb_seq_alu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st32 = 1'b0, st8 = 1'b0;
  logic [3:0]  fn32 = '0, fn8 = '0;
  logic [31:0] a32 = '0, b32 = '0, out32;
  logic [7:0]  a8 = '0, b8 = '0, out8;
  logic        rdy32, dn32, z32, rdy8, dn8, z8;
  logic [63:0] sb[$];
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(st32), .alu_function(fn32), .input_a(a32), .input_b(b32),
    .ready(rdy32), .done(dn32), .alu_output(out32), .zero(z32));
  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .alu_function(fn8), .input_a(a8), .input_b(b8),
    .ready(rdy8), .done(dn8), .alu_output(out8), .zero(z8));

  function automatic logic [63:0] model(input int w, input logic [3:0] op, input logic [63:0] ai, bi);
    logic [63:0] m, sg, p, a, b;
    int sh;
    m = (64'd1 << w) - 64'd1;
    a = ai & m;
    b = bi & m;
    sg = 64'd1 << (w - 1);
    sh = int'(b % 64'(w));
    p = a * b;
    case (op)
      4'd0:  return (a + b) & m;
      4'd1:  return (a - b) & m;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return 64'(a < b);
      4'd5:  return a ^ b;
      4'd6:  return 64'((a ^ sg) < (b ^ sg));
      4'd7:  return (a << sh) & m;
      4'd8:  return a >> sh;
      4'd9:  return ((((a & sg) != 0) ? (a | ~m) : a) >> sh) & m;
      4'd10: return p & m;
      4'd11: return (p >> w) & m;
      4'd12: return (b == 0) ? m : a / b;
      4'd13: return (b == 0) ? a : a % b;
      default: return 64'd0;
    endcase
  endfunction

  function automatic int exp_lat(input int w, input logic [3:0] op, input logic [63:0] bi);
    logic [63:0] b;
    b = bi & ((64'd1 << w) - 64'd1);
    if (op >= 4'd10 && op <= 4'd13 && !(op >= 4'd12 && b == 0)) return w + 1;
    return 1;
  endfunction

  function automatic logic dn_of(input int w);
    return (w == 32) ? dn32 : dn8;
  endfunction

  function automatic logic [63:0] out_of(input int w);
    return (w == 32) ? 64'(out32) : 64'(out8);
  endfunction

  function automatic logic z_of(input int w);
    return (w == 32) ? z32 : z8;
  endfunction

  task automatic drive(input int w, input logic s, input logic [3:0] op, input logic [63:0] a, b);
    if (w == 32) begin
      st32 = s; fn32 = op; a32 = a[31:0]; b32 = b[31:0];
    end else begin
      st8 = s; fn8 = op; a8 = a[7:0]; b8 = b[7:0];
    end
  endtask

  task automatic issue(input int w, input logic [3:0] op, input logic [63:0] a, b, input string nm);
    logic [63:0] exp;
    int lat, cyc;
    sb.push_back(model(w, op, a, b));
    lat = exp_lat(w, op, b);
    @(negedge clk);
    drive(w, 1'b1, op, a, b);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) drive(w, 1'b0, 4'd0, 64'd0, 64'd0);
    end while (!dn_of(w) && cyc < 100);
    n_chk++;
    if (!dn_of(w)) begin
      n_fail++;
      $display("FAIL %s: no done within %0d cycles", nm, cyc);
      sb.delete();
    end else begin
      exp = sb.pop_front();
      if (out_of(w) !== exp) begin
        n_fail++;
        $display("FAIL %s result: got %h want %h", nm, out_of(w), exp);
      end
      n_chk++;
      if (z_of(w) !== (exp == 0)) begin
        n_fail++;
        $display("FAIL %s zero: got %b want %b", nm, z_of(w), exp == 0);
      end
      n_chk++;
      if (cyc != lat) begin
        n_fail++;
        $display("FAIL %s latency: got %0d want %0d", nm, cyc, lat);
      end
      @(posedge clk); #1;
      n_chk++;
      if (dn_of(w) !== 1'b0 || out_of(w) !== exp) begin
        n_fail++;
        $display("FAIL %s hold: done %b out %h want done 0 out %h", nm, dn_of(w), out_of(w), exp);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({rdy32, dn32, out32, z32} !== {1'b1, 1'b0, 32'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset32: rdy %b done %b out %h zero %b want 1 0 0 1", rdy32, dn32, out32, z32);
    end
    n_chk++;
    if ({rdy8, dn8, out8, z8} !== {1'b1, 1'b0, 8'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset8: rdy %b done %b out %h zero %b want 1 0 0 1", rdy8, dn8, out8, z8);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    issue(32, 4'd0, 64'hFFFFFFFF, 64'd1, "add_wrap");
    issue(32, 4'd1, 64'd5, 64'd7, "sub");
    issue(32, 4'd6, 64'hFFFFFFFF, 64'd1, "slt");
    issue(32, 4'd4, 64'hFFFFFFFF, 64'd1, "sltu");
    issue(32, 4'd9, 64'h80000000, 64'd4, "sra");
    issue(32, 4'd7, 64'd1, 64'd35, "sll");
    issue(32, 4'd8, 64'hF0000000, 64'd36, "srl");
    issue(32, 4'd2, 64'hF0F0F0F0, 64'h0FF00FF0, "and");
    issue(32, 4'd3, 64'hF0F0F0F0, 64'h0FF00FF0, "or");
    issue(32, 4'd5, 64'hF0F0F0F0, 64'h0FF00FF0, "xor");
    issue(32, 4'd14, 64'h1234, 64'h5678, "rsv14");
    issue(32, 4'd15, 64'h1234, 64'h5678, "rsv15");
  endtask

  task automatic test_reset_mid_mul();
    int seen;
    @(negedge clk);
    drive(32, 1'b1, 4'd10, 64'h1234, 64'h5678);
    @(posedge clk); #1;
    drive(32, 1'b0, 4'd0, 64'd0, 64'd0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({rdy32, dn32, out32, z32} !== {1'b1, 1'b0, 32'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_mid_mul: rdy %b done %b out %h zero %b want 1 0 0 1", rdy32, dn32, out32, z32);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (dn32) seen++;
    end
    n_chk++;
    if (seen != 0 || rdy32 !== 1'b1 || out32 !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_abort: done pulses %0d rdy %b out %h want 0 1 0", seen, rdy32, out32);
    end
  endtask

  task automatic test_muldiv(input int w);
    string p;
    p = (w == 32) ? "w32_" : "w8_";
    if (w == 32) begin
      issue(w, 4'd10, 64'h10000, 64'h10000, {p, "mul"});
      issue(w, 4'd11, 64'h10000, 64'h10000, {p, "mulhu"});
    end else begin
      issue(w, 4'd10, 64'h10, 64'h10, {p, "mul"});
      issue(w, 4'd11, 64'h10, 64'h10, {p, "mulhu"});
    end
    issue(w, 4'd10, 64'hFFFFFFFF, 64'hFFFFFFFF, {p, "mul_max"});
    issue(w, 4'd11, 64'hFFFFFFFF, 64'hFFFFFFFF, {p, "mulhu_max"});
    issue(w, 4'd12, 64'd100, 64'd7, {p, "divu"});
    issue(w, 4'd13, 64'd100, 64'd7, {p, "remu"});
    issue(w, 4'd12, 64'd9, 64'd0, {p, "divu_by0"});
    issue(w, 4'd13, 64'd9, 64'd0, {p, "remu_by0"});
    issue(w, 4'd12, 64'd5, 64'd200, {p, "divu_small"});
    issue(w, 4'd13, 64'hFFFFFFFF, 64'd1, {p, "remu_by1"});
    for (int i = 0; i < 4; i++)
      issue(w, 4'(10 + i), 64'($urandom), 64'($urandom_range(1, 255)), {p, "rand_md"});
    for (int i = 0; i < 4; i++)
      issue(w, 4'($urandom_range(0, 9)), 64'($urandom), 64'($urandom), {p, "rand_alu"});
  endtask

  task automatic test_ignore_busy();
    int cyc, seen;
    logic [63:0] exp;
    sb.push_back(model(32, 4'd12, 64'd100, 64'd7));
    @(negedge clk);
    drive(32, 1'b1, 4'd12, 64'd100, 64'd7);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) drive(32, 1'b0, 4'd0, 64'd0, 64'd0);
      if (cyc == 5) drive(32, 1'b1, 4'd0, 64'd3, 64'd4);
      if (cyc == 6) drive(32, 1'b0, 4'd0, 64'd0, 64'd0);
    end while (!dn32 && cyc < 100);
    exp = sb.pop_front();
    n_chk++;
    if (!dn32 || out32 !== exp[31:0] || cyc != 33) begin
      n_fail++;
      $display("FAIL ignore_busy: done %b out %h cycles %0d want 1 %h 33", dn32, out32, cyc, exp[31:0]);
    end
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (dn32) seen++;
    end
    n_chk++;
    if (seen != 0 || out32 !== exp[31:0]) begin
      n_fail++;
      $display("FAIL ignore_not_queued: extra done %0d out %h want 0 %h", seen, out32, exp[31:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a, exp;
    int ndone;
    ndone = 0;
    for (int e = 0; e < 8; e++) begin
      @(negedge clk);
      a = 64'(e * 3 + 1);
      drive(32, 1'b1, 4'd0, a, 64'hFFFFFFF0);
      if (e % 2 == 0) sb.push_back(model(32, 4'd0, a, 64'hFFFFFFF0));
      @(posedge clk); #1;
      n_chk++;
      if (e % 2 == 0) begin
        exp = (sb.size() > 0) ? sb.pop_front() : 64'hX;
        if (dn32 !== 1'b1 || out32 !== exp[31:0]) begin
          n_fail++;
          $display("FAIL b2b edge %0d: done %b out %h want 1 %h", e, dn32, out32, exp[31:0]);
        end else ndone++;
      end else if (dn32 !== 1'b0 || rdy32 !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b edge %0d: done %b ready %b want 0 1", e, dn32, rdy32);
      end
    end
    @(negedge clk);
    drive(32, 1'b0, 4'd0, 64'd0, 64'd0);
    repeat (2) @(posedge clk);
    n_chk++;
    if (ndone != 4) begin
      n_fail++;
      $display("FAIL b2b count: got %0d want 4", ndone);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset_mid_mul();
    test_muldiv(32);
    test_muldiv(8);
    test_ignore_busy();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the single-cycle datapath ALU.
- Adds signed compare, shifts, and iterative multiply/divide/remainder.
- Uses a start/ready/done handshake so the multi-cycle datapath controller can stall while an operation runs.
- Sits between the register-file read stage and the writeback mux.

Parameters:
- WIDTH, 32: operand and result width in bits (min 4).
- CNT_W, $clog2(WIDTH)+1: width of the iteration counter (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only while ready=1
- alu_function  input  4  operation code, captured with start
- input_a  input  WIDTH  operand A, captured with start
- input_b  input  WIDTH  operand B, captured with start
- ready  output  1  idle, can accept start
- done  output  1  one-cycle pulse: result valid
- alu_output  output  WIDTH  registered result, held until the next done
- zero  output  1  registered; 1 when alu_output == 0

Behaviour:
- Opcodes:
  - 0000 add; 0001 sub; 0010 and; 0011 or; 0100 sltu (unsigned, result 0/1); 0101 xor
  - 0110 slt (signed two's complement, 0/1)
  - 0111 sll; 1000 srl; 1001 sra (shift amount = input_b[$clog2(WIDTH)-1:0])
  - 1010 mul (low WIDTH bits of unsigned product); 1011 mulhu (high WIDTH bits)
  - 1100 divu (unsigned quotient); 1101 remu (unsigned remainder)
  - 1110, 1111 reserved: result 0
- Add/sub wrap modulo 2^WIDTH; no carry or overflow output.
- Reset (async, rst_n=0):
  - state=IDLE, ready=1, done=0, alu_output=0, zero=1, counter=0.
  - Reset mid-operation aborts it; no done pulse follows.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - start=1 captures the operands and opcode.
  - Single-cycle opcodes (0000-1001, 1110, 1111): compute, go to DONE.
  - 1010/1011: load multiplicand/multiplier, accumulator=0, counter=WIDTH, go to MUL.
  - 1100/1101: load the restoring-division registers, counter=WIDTH, go to DIV.
- MUL: one shift-add step per cycle; counter decrements; on counter==1 the last step executes and the FSM goes to DONE.
- DIV: one restoring subtract/shift step per cycle, same counter rule.
- Divide by zero:
  - Detected at capture. Skip DIV and go straight to DONE.
  - divu result = all ones; remu result = input_a.
- DONE (exactly one cycle):
  - alu_output/zero update on entry to DONE, so they are valid in the same cycle done=1.
  - done=1, ready=0; returns to IDLE next cycle.
- ready=1 only in IDLE. start while ready=0 is ignored, not queued.
- Operand inputs may change freely after capture.
- Latency from the start edge to the done cycle:
  - single-cycle ops and divide by zero: 1 cycle.
  - mul/mulhu/divu/remu: WIDTH+1 cycles.
  - Throughput: one op per (latency+1) cycles.
- alu_output/zero hold their value outside DONE, including during subsequent busy cycles.
- start and an rst_n deassertion in the same cycle: start is sampled only if rst_n=1 at the clock edge.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams (ALU_ADD ... ALU_REMU)
  - FSM state encoding (2-bit)
- Sub-module seq_alu_muldiv: iterative mul/div datapath with load/step/counter ports.
- Single-cycle ops stay inline in seq_alu.

Test Plan:
- Reset asserted mid-MUL (WIDTH=32): raise rst_n -> ready=1, alu_output=0, zero=1, no done pulse.
- add 0xFFFFFFFF+1 -> done one cycle after start, alu_output=0, zero=1. sub 5-7 -> 0xFFFFFFFE.
- slt 0xFFFFFFFF vs 1 -> 1. sltu same operands -> 0. sra 0x80000000 by 4 -> 0xF8000000. sll 1 by 35 -> 0x00000008.
- mul 0x10000 × 0x10000 -> alu_output=0 after 33 cycles; mulhu same operands -> 0x00000001; done high for exactly 1 cycle.
- divu 100/7 -> 14; remu -> 2, each 33 cycles. divu 9/0 -> 0xFFFFFFFF and remu 9/0 -> 9, each in 1 cycle.
- start pulsed during DIV with other operands -> ignored; first result unchanged. Back-to-back add starts -> one result every 2 cycles. Repeat the mul/div checks with WIDTH=8 (latency 9).
